// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory between instruction fetch and load/store,
// D-priority with a streak limit so fetch cannot starve.
module mem_arbiter #(
    parameter int AWIDTH          = 32,
    parameter int DWIDTH          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [2:0]        d_size_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [2:0]        mem_size_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);
    localparam logic [2:0] MEM_WORD = 3'd2;
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              owner_d_q;
    logic              we_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        size_q;
    logic [DWIDTH-1:0] if_rdata_q, d_rdata_q;
    logic              can_gnt, if_wins;

    always_comb begin
        // No grant while reset is asserted so every output reads 0 in reset.
        can_gnt  = rst && (state_q != ACCESS);
        if_wins  = if_req_i && (streak_q == STREAK_MAX);
        d_gnt_o  = can_gnt && d_req_i && !if_wins;
        if_gnt_o = can_gnt && if_req_i && !d_gnt_o;
        state_d  = (state_q == ACCESS) ? RESP : (d_gnt_o || if_gnt_o) ? ACCESS : IDLE;
        streak_d = if_gnt_o ? '0 :
                   !d_gnt_o ? streak_q :
                   !if_req_i ? '0 :
                   (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_d_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (d_gnt_o) begin
                owner_d_q <= 1'b1;
                we_q      <= d_we_i;
                addr_q    <= d_addr_i;
                wdata_q   <= d_wdata_i;
                size_q    <= d_size_i;
            end else if (if_gnt_o) begin
                owner_d_q <= 1'b0;
                we_q      <= 1'b0;
                addr_q    <= if_addr_i;
                size_q    <= MEM_WORD;
            end
            if (state_q == ACCESS) begin
                if (owner_d_q) d_rdata_q <= we_q ? '0 : mem_data_i;
                else if_rdata_q <= mem_data_i;
            end
        end
    end

    assign mem_addr_o     = addr_q;
    assign mem_data_o     = wdata_q;
    assign mem_size_o     = size_q;
    assign mem_read_en_o  = (state_q == ACCESS) && !we_q;
    assign mem_write_en_o = (state_q == ACCESS) && we_q;
    assign if_rvalid_o    = (state_q == RESP) && !owner_d_q;
    assign d_rvalid_o     = (state_q == RESP) && owner_d_q;
    assign if_rdata_o     = if_rdata_q;
    assign d_rdata_o      = d_rdata_q;
endmodule
